pipelined_decoder: RTL and testbench
====================================

PIPELINED_DECODER -- requirements
Module: pipelined_decoder

Interface
REQ-001 SHALL have parameter IMM_W, default 32, the immediate output width; legal values are 16 to 64.
REQ-002 SHALL have parameter DEPTH, default 2, the decoded-entry buffer depth; legal values are powers of two, 2 or greater.
REQ-003 SHALL use one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port ins  input  32  raw instruction word.
REQ-006 SHALL have port in_valid  input  1  ins is valid this cycle.
REQ-007 SHALL have port in_ready  output  1  buffer can accept an entry.
REQ-008 SHALL have port flush  input  1  synchronous discard of all buffered entries.
REQ-009 SHALL have port out_valid  output  1  head entry is valid.
REQ-010 SHALL have port out_ready  input  1  consumer takes the head entry.
REQ-011 SHALL have ports opcode (6 bits), funct (6 bits), rs, rt, rd and shamt (5 bits each), all outputs, carrying the head-entry fields.
REQ-012 SHALL have outputs imm (IMM_W bits), is_itype (1 bit) and is_nop (1 bit), carrying the head-entry immediate and class flags.

Function
REQ-013 SHALL decode opcode=ins[31:26], rs=ins[25:21] and rt=ins[20:16] for every word.
REQ-014 SHALL treat ins[30]=1 as I-type:
- is_itype=1.
- imm = ins[15:0] sign-extended to IMM_W.
- rd, shamt and funct are 0.
REQ-015 SHALL treat ins[30]=0 with ins nonzero as R-type:
- rd=ins[15:11], shamt=ins[10:6], funct=ins[5:0].
- imm=0, is_itype=0.
REQ-016 SHALL treat ins=0 as NOP: is_nop=1 and every field output is 0.
REQ-017 SHALL decode at push time and store decoded fields, not raw words, in a DEPTH-entry FIFO.
REQ-018 SHALL push when in_valid and in_ready are both 1, and pop when out_valid and out_ready are both 1.
REQ-019 SHALL have one-cycle latency: an entry pushed into an empty buffer at edge N is presented with out_valid=1 after edge N.
REQ-020 SHALL derive in_ready only from occupancy: in_ready = (occupancy < DEPTH); a pop in the same cycle does not enable a push when the buffer is full.
REQ-021 SHALL, on a simultaneous push and pop at non-full, non-empty occupancy, leave occupancy unchanged.
REQ-022 SHALL wrap read and write pointers modulo DEPTH.
REQ-023 SHALL drive all field outputs and flags to 0 when the buffer is empty, including out_valid=0.
REQ-024 SHALL hold head fields stable while out_valid=1 and out_ready=0.
REQ-025 SHALL, on flush=1, empty the buffer at the next edge; any push or pop in that cycle is discarded and in_ready stays asserted.

Reset
REQ-026 SHALL, while rst_n=0, immediately set the following, regardless of clk:
- occupancy and pointers to 0.
- out_valid=0, in_ready=1, all field outputs 0.
- all counters 0.
REQ-027 SHALL discard all buffered entries on reset assertion mid-operation, and SHALL accept a push on the first rising edge after rst_n deasserts.

Configuration
REQ-028 SHALL compile the statistics feature only when macro DECODER_STATS_EN is defined.
- Defined: 32-bit outputs instr_cnt (counts pops) and nop_cnt (counts pops with is_nop=1).
- Both counters wrap modulo 2^32 and are not cleared by flush.
- Undefined: neither port nor counter logic exists, and all other behaviour is identical.

Verification
REQ-029 SHALL cover I-type sign extension: with IMM_W=32, ins=0x4000FFFF, out_ready=1 -> next cycle out_valid=1, opcode=0x10, imm=0xFFFFFFFF, is_itype=1, rd=0.
REQ-030 SHALL cover R-type and NOP decode: ins=0x00221820 -> rs=1, rt=2, rd=3, shamt=0, funct=0x20; then ins=0 -> is_nop=1 and all field outputs 0.
REQ-031 SHALL cover full and backpressure: with DEPTH=2, out_ready=0 and 3 pushes attempted -> in_ready=0 after 2 accepted; raising out_ready pops them in order and the third push succeeds afterwards.
REQ-032 SHALL cover flush precedence: 2 entries buffered, flush=1 together with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the pushed word is lost.
REQ-033 SHALL cover mid-operation reset: rst_n=0 between clock edges with 1 entry buffered -> out_valid=0 immediately and instr_cnt=0.
REQ-034 SHALL cover counter wrap with DECODER_STATS_EN: instr_cnt forced to 0xFFFFFFFF, then one pop of a NOP -> instr_cnt=0 and nop_cnt incremented by 1.

Source files
------------

// File: rtl/pipelined_decoder.sv
// Decodes 32-bit instruction words at push time and buffers the decoded
// fields in a DEPTH-entry FIFO with valid/ready handshakes on both sides.
// Ports: clk, rst_n (async, active-low); ins/in_valid/in_ready push side;
//   flush drops all entries; out_valid/out_ready pop side; opcode, rs, rt,
//   rd, shamt, funct, imm, is_itype, is_nop carry the head entry (0 if empty).
// Macro DECODER_STATS_EN adds instr_cnt/nop_cnt pop counters.
module pipelined_decoder #(
    parameter int IMM_W = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      ins,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [5:0]       opcode,
    output logic [5:0]       funct,
    output logic [4:0]       rs,
    output logic [4:0]       rt,
    output logic [4:0]       rd,
    output logic [4:0]       shamt,
    output logic [IMM_W-1:0] imm,
    output logic             is_itype,
    output logic             is_nop
`ifdef DECODER_STATS_EN
    ,
    output logic [31:0]      instr_cnt,
    output logic [31:0]      nop_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [5:0]       opcode;
        logic [4:0]       rs;
        logic [4:0]       rt;
        logic [4:0]       rd;
        logic [4:0]       shamt;
        logic [5:0]       funct;
        logic [IMM_W-1:0] imm;
        logic             itype;
        logic             nop;
    } entry_t;

    entry_t          dec;
    entry_t          head;
    entry_t          mem_q [DEPTH];
    logic [AW-1:0]   wptr_q, wptr_d;
    logic [AW-1:0]   rptr_q, rptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            push, pop;

    // ins == 0 implies ins[30] == 0, so the two arms never overlap.
    always_comb begin
        dec = '0;
        unique case (1'b1)
            (ins == 32'd0): begin
                dec.nop = 1'b1;
            end
            ins[30]: begin
                dec.opcode = ins[31:26];
                dec.rs     = ins[25:21];
                dec.rt     = ins[20:16];
                dec.imm    = IMM_W'(signed'(ins[15:0]));
                dec.itype  = 1'b1;
            end
            default: begin
                dec.opcode = ins[31:26];
                dec.rs     = ins[25:21];
                dec.rt     = ins[20:16];
                dec.rd     = ins[15:11];
                dec.shamt  = ins[10:6];
                dec.funct  = ins[5:0];
            end
        endcase
    end

    // Readiness depends on occupancy only; a same-cycle pop never frees a
    // slot for a push, and flush squashes both handshakes.
    assign in_ready  = (cnt_q < CW'(DEPTH));
    assign out_valid = (cnt_q != '0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            // Pointers are AW bits wide, so +1 wraps modulo DEPTH.
            if (push) wptr_d = wptr_q + 1'b1;
            if (pop)  rptr_d = rptr_q + 1'b1;
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            if (push) mem_q[wptr_q] <= dec;
        end
    end

    assign head     = out_valid ? mem_q[rptr_q] : '0;
    assign opcode   = head.opcode;
    assign rs       = head.rs;
    assign rt       = head.rt;
    assign rd       = head.rd;
    assign shamt    = head.shamt;
    assign funct    = head.funct;
    assign imm      = head.imm;
    assign is_itype = head.itype;
    assign is_nop   = head.nop;

`ifdef DECODER_STATS_EN
    logic [31:0] instr_cnt_q, instr_cnt_d;
    logic [31:0] nop_cnt_q, nop_cnt_d;

    // Counters survive flush; only reset clears them.
    always_comb begin
        instr_cnt_d = instr_cnt_q;
        nop_cnt_d   = nop_cnt_q;
        if (pop) begin
            instr_cnt_d = instr_cnt_q + 32'd1;
            if (head.nop) nop_cnt_d = nop_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_cnt_q <= '0;
            nop_cnt_q   <= '0;
        end else begin
            instr_cnt_q <= instr_cnt_d;
            nop_cnt_q   <= nop_cnt_d;
        end
    end

    assign instr_cnt = instr_cnt_q;
    assign nop_cnt   = nop_cnt_q;
`endif

endmodule

// File: tb/tb_pipelined_decoder.sv
// Self-checking bench for pipelined_decoder (IMM_W=32, DEPTH=2):
// decode vector table, handshake corner cases, randomized model check.
module tb_pipelined_decoder;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ins;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [31:0] imm;
    logic        is_itype, is_nop;
`ifdef DECODER_STATS_EN
    logic [31:0] instr_cnt, nop_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    pipelined_decoder #(.IMM_W(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .ins(ins), .in_valid(in_valid),
        .in_ready(in_ready), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .opcode(opcode), .funct(funct),
        .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .imm(imm),
        .is_itype(is_itype), .is_nop(is_nop)
`ifdef DECODER_STATS_EN
        , .instr_cnt(instr_cnt), .nop_cnt(nop_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  sh;
        logic [5:0]  fn;
        logic [31:0] imm;
        logic        it;
        logic        nop;
    } dec_t;

    typedef struct {
        logic [31:0] ins;
        dec_t        e;
    } vec_t;

    function automatic dec_t ref_dec(logic [31:0] w);
        dec_t d = '0;
        if (w != 32'd0) begin
            d.op = w[31:26];
            d.rs = w[25:21];
            d.rt = w[20:16];
            if (w[30]) begin
                d.it  = 1'b1;
                d.imm = w[15] ? {16'hFFFF, w[15:0]} : {16'h0000, w[15:0]};
            end else begin
                d.rd = w[15:11];
                d.sh = w[10:6];
                d.fn = w[5:0];
            end
        end else begin
            d.nop = 1'b1;
        end
        return d;
    endfunction

    task automatic chk(string nm, logic [95:0] got, logic [95:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic chk_head(string nm, bit v, dec_t e);
        dec_t got;
        got = {opcode, rs, rt, rd, shamt, funct, imm, is_itype, is_nop};
        chk({nm, ".valid"}, 96'(out_valid), 96'(v));
        chk({nm, ".fields"}, 96'(got), v ? 96'(e) : 96'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #7;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    vec_t vecs[7];
    dec_t q[$];
    dec_t da, db, dc;
    logic [31:0] wa, wb, wc, w;
    bit   pu, po;
`ifdef DECODER_STATS_EN
    logic [31:0] nop_before;
`endif

    initial begin
        vecs[0] = '{32'h4000FFFF, '{6'h10, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00,
                                    32'hFFFFFFFF, 1'b1, 1'b0}};
        vecs[1] = '{32'h00221820, '{6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20,
                                    32'h0, 1'b0, 1'b0}};
        vecs[2] = '{32'h00000000, '{6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00,
                                    32'h0, 1'b0, 1'b1}};
        vecs[3] = '{32'h7FFF1234, '{6'h1F, 5'd31, 5'd31, 5'd0, 5'd0, 6'h00,
                                    32'h00001234, 1'b1, 1'b0}};
        vecs[4] = '{32'h8C6A7FC5, '{6'h23, 5'd3, 5'd10, 5'd15, 5'd31, 6'h05,
                                    32'h0, 1'b0, 1'b0}};
        vecs[5] = '{32'hC0008000, '{6'h30, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00,
                                    32'hFFFF8000, 1'b1, 1'b0}};
        vecs[6] = '{32'h00000001, '{6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 6'h01,
                                    32'h0, 1'b0, 1'b0}};

        ins = '0; in_valid = 0; flush = 0; out_ready = 0;
        rst_n = 1'b0;
        #3;
        chk_head("reset", 1'b0, '0);
        chk("reset.in_ready", 96'(in_ready), 96'd1);
`ifdef DECODER_STATS_EN
        chk("reset.instr_cnt", 96'(instr_cnt), 96'd0);
`endif
        do_reset();

        // decode table: push one word, inspect head, pop it
        for (int i = 0; i < 7; i++) begin
            ins = vecs[i].ins; in_valid = 1;
            step();
            in_valid = 0;
            chk_head($sformatf("vec%0d", i), 1'b1, vecs[i].e);
            out_ready = 1;
            step();
            out_ready = 0;
            chk_head($sformatf("vec%0d.pop", i), 1'b0, '0);
        end

        // full buffer and backpressure
        wa = 32'h00221820; wb = 32'h4000FFFF; wc = 32'h8C6A7FC5;
        da = ref_dec(wa); db = ref_dec(wb); dc = ref_dec(wc);
        in_valid = 1; ins = wa; step();
        ins = wb; step();
        chk("full.in_ready", 96'(in_ready), 96'd0);
        ins = wc; step();
        chk("full.hold_ready", 96'(in_ready), 96'd0);
        chk_head("full.headA", 1'b1, da);
        out_ready = 1; step();
        chk_head("full.headB", 1'b1, db);
        chk("full.ready_after_pop", 96'(in_ready), 96'd1);
        step();
        in_valid = 0;
        chk_head("full.headC", 1'b1, dc);
        step();
        out_ready = 0;
        chk_head("full.empty", 1'b0, '0);

        // flush with full buffer and a push attempt
        in_valid = 1; ins = wa; step();
        ins = wb; step();
        ins = wc; flush = 1; step();
        flush = 0; in_valid = 0;
        chk_head("flush2.empty", 1'b0, '0);
        chk("flush2.in_ready", 96'(in_ready), 96'd1);
        step();
        chk_head("flush2.lost", 1'b0, '0);

        // flush with one entry; the push in that cycle must be lost
        in_valid = 1; ins = wa; step();
        ins = wb; flush = 1; out_ready = 1; step();
        flush = 0; in_valid = 0; out_ready = 0;
        chk_head("flush1.empty", 1'b0, '0);
        chk("flush1.in_ready", 96'(in_ready), 96'd1);

        // reset between edges with one entry buffered
        in_valid = 1; ins = wb; step();
        in_valid = 0;
        chk_head("mrst.before", 1'b1, db);
        #2;
        rst_n = 0;
        #1;
        chk_head("mrst.now", 1'b0, '0);
        chk("mrst.in_ready", 96'(in_ready), 96'd1);
`ifdef DECODER_STATS_EN
        chk("mrst.instr_cnt", 96'(instr_cnt), 96'd0);
`endif
        @(negedge clk);
        rst_n = 1;
        in_valid = 1; ins = wc;
        step();
        in_valid = 0;
        chk_head("mrst.first_push", 1'b1, dc);
        out_ready = 1; step(); out_ready = 0;

`ifdef DECODER_STATS_EN
        // counter wrap on a NOP pop
        nop_before = nop_cnt;
        in_valid = 1; ins = 32'd0; step();
        in_valid = 0;
        force dut.instr_cnt_q = 32'hFFFFFFFF;
        #1;
        release dut.instr_cnt_q;
        out_ready = 1; step(); out_ready = 0;
        chk("wrap.instr_cnt", 96'(instr_cnt), 96'd0);
        chk("wrap.nop_cnt", 96'(nop_cnt), 96'(nop_before + 32'd1));
`endif

        // randomized traffic against a queue model
        q.delete();
        for (int i = 0; i < 2000; i++) begin
            case ($urandom_range(0, 3))
                0: w = 32'd0;
                default: w = $urandom;
            endcase
            ins = w;
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 31) == 0);
            #1;
            chk("rnd.in_ready", 96'(in_ready), 96'(q.size() < DEPTH));
            if (q.size() > 0) chk_head("rnd.head", 1'b1, q[0]);
            else chk_head("rnd.head", 1'b0, '0);
            pu = in_valid && (q.size() < DEPTH);
            po = out_ready && (q.size() > 0);
            step();
            if (flush) q.delete();
            else begin
                if (po) void'(q.pop_front());
                if (pu) q.push_back(ref_dec(w));
            end
        end
        in_valid = 0; flush = 0; out_ready = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
